// File: rtl/dmem_ctrl.sv
// Data-memory controller between a stalling CPU port, a write-through
// no-write-allocate data cache and a fixed-latency data memory.
// Read hits complete in one cycle; read misses wait MEM_LAT cycles on memory,
// fill the cache line and respond; writes go to memory (and to the cache only
// when the line is already present) and respond after MEM_LAT cycles.
module dmem_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [7:0]  cache_addr,
  input  logic        cache_hit,
  input  logic [15:0] cache_rdata,
  output logic        cache_dwe,
  output logic [15:0] cache_wdata,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MRD  = 3'd1;
  localparam logic [2:0] FILL = 3'd2;
  localparam logic [2:0] MWR  = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  // Wait counter is loaded with the last index so MRD/MWR last MEM_LAT cycles.
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]  state;
  logic        we_l;
  logic        hit_l;
  logic [7:0]  addr_l;
  logic [15:0] wdata_l;
  logic [15:0] rdata_r;
  logic [3:0]  wait_cnt;
  logic        accept;
  logic        first_mwr;

  assign accept    = (state == IDLE) && cpu_req;
  assign first_mwr = (state == MWR) && (wait_cnt == LAT_LAST);

  // Request capture: fields are sampled only at acceptance, so the CPU may
  // change them freely while the access is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_l    <= 1'b0;
      hit_l   <= 1'b0;
      addr_l  <= 8'h00;
      wdata_l <= 16'h0000;
    end else if (accept) begin
      we_l    <= cpu_we;
      hit_l   <= cache_hit;
      addr_l  <= cpu_addr;
      wdata_l <= cpu_wdata;
    end
  end

  // Access sequencer: IDLE -> (RESP | MRD..FILL | MWR) -> RESP -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wait_cnt <= LAT_LAST;
            if (cpu_we)         state <= MWR;
            else if (cache_hit) state <= RESP;
            else                state <= MRD;
          end
        end
        MRD: begin
          if (wait_cnt == 4'd0) state <= FILL;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        FILL: state <= RESP;
        MWR: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read-data register: loaded from the cache on a hit or from memory on
  // fill; writes leave it alone so the CPU sees the last read value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= 16'h0000;
    end else if (accept && !cpu_we && cache_hit) begin
      rdata_r <= cache_rdata;
    end else if (state == FILL) begin
      rdata_r <= mem_rdata;
    end
  end

  // Hit/miss statistics, counted once per accepted read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else if (accept && !cpu_we) begin
      if (cache_hit) hit_count  <= sat_inc(hit_count);
      else           miss_count <= sat_inc(miss_count);
    end
  end

  // Output decode: every strobe is a pure function of the state, so reset
  // clears them immediately and an aborted access never emits a write.
  always_comb begin
    cpu_ready   = (state == RESP);
    cpu_rdata   = rdata_r;
    cache_addr  = (state == IDLE) ? cpu_addr : addr_l;
    cache_dwe   = (state == FILL) || (first_mwr && hit_l);
    cache_wdata = (state == FILL) ? mem_rdata : wdata_l;
    mem_addr    = addr_l;
    mem_we      = first_mwr;
    mem_wdata   = wdata_l;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with MEM_LAT=2. Cache and memory responses are
// driven as fixed values per scenario; every expectation is hand-computed.
module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic [7:0]  cache_addr;
  logic        cache_hit;
  logic [15:0] cache_rdata;
  logic        cache_dwe;
  logic [15:0] cache_wdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks;
  int errors;

  dmem_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cache_addr(cache_addr), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .cache_dwe(cache_dwe), .cache_wdata(cache_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    cache_hit = 1'b0; cache_rdata = 16'h0000; mem_rdata = 16'h0000;
    step(); step();
    chk("rst_ready", {15'd0, cpu_ready}, 16'd0);
    chk("rst_dwe", {15'd0, cache_dwe}, 16'd0);
    chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    chk("rst_hit", hit_count, 16'd0);
    chk("rst_miss", miss_count, 16'd0);
    chk("rst_mem_addr", {8'd0, mem_addr}, 16'd0);
    reset = 1'b0;
    step();
    chk("idle_ready", {15'd0, cpu_ready}, 16'd0);
  endtask

  task automatic test_read_hit();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    cache_hit = 1'b1; cache_rdata = 16'hBEEF;
    #1;
    chk("hit_idle_cache_addr", {8'd0, cache_addr}, 16'h0010);
    step();
    chk("hit_ready", {15'd0, cpu_ready}, 16'd1);
    chk("hit_rdata", cpu_rdata, 16'hBEEF);
    chk("hit_count", hit_count, 16'd1);
    chk("hit_mem_we", {15'd0, mem_we}, 16'd0);
    chk("hit_miss_count", miss_count, 16'd0);
    cpu_req = 1'b0; cache_hit = 1'b0; cache_rdata = 16'h0000;
    step();
    chk("hit_ready_drop", {15'd0, cpu_ready}, 16'd0);
  endtask

  task automatic test_read_miss();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    cache_hit = 1'b0; mem_rdata = 16'h1234;
    step();
    chk("miss_c1_ready", {15'd0, cpu_ready}, 16'd0);
    chk("miss_c1_dwe", {15'd0, cache_dwe}, 16'd0);
    chk("miss_mem_addr", {8'd0, mem_addr}, 16'h0020);
    chk("miss_count", miss_count, 16'd1);
    chk("miss_hit_count", hit_count, 16'd1);
    cpu_req = 1'b0; cpu_addr = 8'h77;
    #1;
    chk("miss_cache_addr_held", {8'd0, cache_addr}, 16'h0020);
    step();
    chk("miss_c2_ready", {15'd0, cpu_ready}, 16'd0);
    chk("miss_c2_dwe", {15'd0, cache_dwe}, 16'd0);
    step();
    chk("miss_fill_dwe", {15'd0, cache_dwe}, 16'd1);
    chk("miss_fill_wdata", cache_wdata, 16'h1234);
    chk("miss_fill_ready", {15'd0, cpu_ready}, 16'd0);
    step();
    chk("miss_c4_ready", {15'd0, cpu_ready}, 16'd1);
    chk("miss_c4_rdata", cpu_rdata, 16'h1234);
    chk("miss_c4_dwe", {15'd0, cache_dwe}, 16'd0);
    step();
    chk("miss_done_ready", {15'd0, cpu_ready}, 16'd0);
  endtask

  task automatic test_write();
    // write hit
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'hA5A5; cache_hit = 1'b1;
    step();
    chk("wh_c1_mem_we", {15'd0, mem_we}, 16'd1);
    chk("wh_c1_mem_wdata", mem_wdata, 16'hA5A5);
    chk("wh_c1_mem_addr", {8'd0, mem_addr}, 16'h0005);
    chk("wh_c1_dwe", {15'd0, cache_dwe}, 16'd1);
    chk("wh_c1_cache_wdata", cache_wdata, 16'hA5A5);
    chk("wh_c1_ready", {15'd0, cpu_ready}, 16'd0);
    cpu_req = 1'b0; cpu_we = 1'b0; cache_hit = 1'b0;
    step();
    chk("wh_c2_mem_we", {15'd0, mem_we}, 16'd0);
    chk("wh_c2_dwe", {15'd0, cache_dwe}, 16'd0);
    chk("wh_c2_ready", {15'd0, cpu_ready}, 16'd0);
    step();
    chk("wh_c3_ready", {15'd0, cpu_ready}, 16'd1);
    chk("wh_c3_rdata", cpu_rdata, 16'h1234);
    chk("wh_hit_count", hit_count, 16'd1);
    chk("wh_miss_count", miss_count, 16'd1);
    step();
    // write miss
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h06; cpu_wdata = 16'h5A5A; cache_hit = 1'b0;
    step();
    chk("wm_c1_mem_we", {15'd0, mem_we}, 16'd1);
    chk("wm_c1_mem_wdata", mem_wdata, 16'h5A5A);
    chk("wm_c1_dwe", {15'd0, cache_dwe}, 16'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    chk("wm_c2_dwe", {15'd0, cache_dwe}, 16'd0);
    chk("wm_c2_mem_we", {15'd0, mem_we}, 16'd0);
    step();
    chk("wm_c3_ready", {15'd0, cpu_ready}, 16'd1);
    chk("wm_c3_dwe", {15'd0, cache_dwe}, 16'd0);
    chk("wm_hit_count", hit_count, 16'd1);
    chk("wm_miss_count", miss_count, 16'd1);
    step();
  endtask

  task automatic test_saturation();
    // Preload stands in for a long run of hits.
    force dut.hit_count = 16'hFFFE;
    #1;
    release dut.hit_count;
    #1;
    chk("sat_preload", hit_count, 16'hFFFE);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30; cache_hit = 1'b1; cache_rdata = 16'h1111;
    step();
    chk("sat_ready1", {15'd0, cpu_ready}, 16'd1);
    chk("sat_count1", hit_count, 16'hFFFF);
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1; cpu_addr = 8'h31; cache_rdata = 16'h2222;
    step();
    chk("sat_ready2", {15'd0, cpu_ready}, 16'd1);
    chk("sat_rdata2", cpu_rdata, 16'h2222);
    chk("sat_count2", hit_count, 16'hFFFF);
    chk("sat_miss", miss_count, 16'd1);
    cpu_req = 1'b0; cache_hit = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40; cache_hit = 1'b1; cache_rdata = 16'hAAAA;
    step();
    chk("b2b_ready1", {15'd0, cpu_ready}, 16'd1);
    chk("b2b_rdata1", cpu_rdata, 16'hAAAA);
    cpu_addr = 8'h41; cache_rdata = 16'hBBBB;
    #1;
    chk("b2b_resp_cache_addr", {8'd0, cache_addr}, 16'h0040);
    step();
    chk("b2b_gap_ready", {15'd0, cpu_ready}, 16'd0);
    chk("b2b_gap_rdata", cpu_rdata, 16'hAAAA);
    chk("b2b_gap_cache_addr", {8'd0, cache_addr}, 16'h0041);
    step();
    chk("b2b_ready2", {15'd0, cpu_ready}, 16'd1);
    chk("b2b_rdata2", cpu_rdata, 16'hBBBB);
    chk("b2b_mem_addr2", {8'd0, mem_addr}, 16'h0041);
    cpu_req = 1'b0; cache_hit = 1'b0;
    step();
    chk("b2b_end_ready", {15'd0, cpu_ready}, 16'd0);
  endtask

  task automatic test_reset_mid_mrd();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h50; cache_hit = 1'b0; mem_rdata = 16'h9999;
    step();
    chk("rmrd_in_mrd_dwe", {15'd0, cache_dwe}, 16'd0);
    cpu_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("rmrd_ready", {15'd0, cpu_ready}, 16'd0);
    chk("rmrd_hit", hit_count, 16'd0);
    chk("rmrd_miss", miss_count, 16'd0);
    chk("rmrd_rdata", cpu_rdata, 16'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rmrd_no_fill", {15'd0, cache_dwe}, 16'd0);
      chk("rmrd_no_ready", {15'd0, cpu_ready}, 16'd0);
      step();
    end
    cpu_req = 1'b1; cpu_addr = 8'h60; mem_rdata = 16'h4321;
    step();
    chk("rmrd_after_miss", miss_count, 16'd1);
    cpu_req = 1'b0;
    step();
    step();
    chk("rmrd_after_fill_dwe", {15'd0, cache_dwe}, 16'd1);
    chk("rmrd_after_fill_wdata", cache_wdata, 16'h4321);
    step();
    chk("rmrd_after_ready", {15'd0, cpu_ready}, 16'd1);
    chk("rmrd_after_rdata", cpu_rdata, 16'h4321);
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write();
    test_saturation();
    test_back_to_back();
    test_reset_mid_mrd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter: MEM_LAT, default 2, data-memory access latency in clk cycles; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cpu_req  input  1  CPU data access request; held high until cpu_ready.
REQ-005 SHALL have port: cpu_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have port: cpu_addr  input  8  data word address.
REQ-007 SHALL have port: cpu_wdata  input  16  write data.
REQ-008 SHALL have port: cpu_rdata  output  16  read data; valid while cpu_ready=1.
REQ-009 SHALL have port: cpu_ready  output  1  one-cycle completion pulse; the CPU stalls while it is 0.
REQ-010 SHALL have port: cache_addr  output  8  cache lookup/update address.
REQ-011 SHALL have port: cache_hit  input  1  combinational hit flag for cache_addr.
REQ-012 SHALL have port: cache_rdata  input  16  cache data for cache_addr.
REQ-013 SHALL have port: cache_dwe  output  1  cache line write strobe.
REQ-014 SHALL have port: cache_wdata  output  16  cache line write data.
REQ-015 SHALL have port: mem_addr  output  8  data memory address.
REQ-016 SHALL have port: mem_we  output  1  data memory write strobe.
REQ-017 SHALL have port: mem_wdata  output  16  data memory write data.
REQ-018 SHALL have port: mem_rdata  input  16  data memory read data; valid MEM_LAT cycles after mem_addr is stable.
REQ-019 SHALL have port: hit_count  output  16  saturating count of read hits.
REQ-020 SHALL have port: miss_count  output  16  saturating count of read misses.

Function
REQ-021 SHALL implement FSM states IDLE, MRD, FILL, MWR, RESP.
REQ-022 SHALL accept a request on the edge where state=IDLE and cpu_req=1, latching cpu_we, cpu_addr, cpu_wdata, and the current cache_hit as hit_l.
REQ-023 SHALL drive cache_addr=cpu_addr in IDLE and the latched address in all other states; mem_addr SHALL always equal the latched address.
REQ-024 SHALL go from IDLE to RESP on an accepted read with hit_l=1, latching cache_rdata into the read-data register.
REQ-025 SHALL go from IDLE to MRD on an accepted read miss, stay in MRD exactly MEM_LAT cycles (4-bit wait counter), then go to FILL.
REQ-026 SHALL, in FILL (one cycle), assert cache_dwe=1, drive cache_wdata=mem_rdata, latch mem_rdata into the read-data register, then go to RESP.
REQ-027 SHALL go from IDLE to MWR on an accepted write and stay in MWR exactly MEM_LAT cycles, then go to RESP.
REQ-028 SHALL, in the first MWR cycle only, assert mem_we=1 with mem_wdata=latched data.
REQ-029 SHALL, in the first MWR cycle only and only if hit_l=1, assert cache_dwe=1 with cache_wdata=latched data; write misses SHALL NOT allocate.
REQ-030 SHALL, in RESP (one cycle), assert cpu_ready=1 with cpu_rdata=read-data register (write: last read value unchanged), then return to IDLE.
REQ-031 SHALL, in IDLE, accept no new request in the same cycle as RESP; minimum request spacing is 2 cycles (hit).
REQ-032 SHALL ignore changes on cpu_* inputs while not in IDLE.
REQ-033 SHALL increment hit_count or miss_count at read acceptance, per hit_l; writes SHALL NOT count; each counter SHALL saturate at 16'hFFFF.
REQ-034 SHALL keep cache_dwe, mem_we and cpu_ready at 0 in every state and cycle not listed above.

Reset
REQ-035 SHALL, while reset=1, immediately force state=IDLE and drive cpu_ready=0, cache_dwe=0, mem_we=0, cpu_rdata=0, hit_count=0 and miss_count=0, with latched registers at 0.
REQ-036 SHALL, when reset is asserted mid-MRD/MWR/FILL, abort without completing the pending cache or memory write and without emitting cpu_ready; the first access after release is accepted from IDLE.

Verification
REQ-037 SHALL verify a read hit: MEM_LAT=2, read addr 0x10 with cache_hit=1 and cache_rdata=0xBEEF -> cpu_ready exactly 1 cycle after accept, cpu_rdata=0xBEEF, hit_count=1, mem_we=0.
REQ-038 SHALL verify a read miss: addr 0x20 with cache_hit=0 and mem_rdata=0x1234 -> 2 MRD cycles, a FILL cycle with cache_dwe=1 and cache_wdata=0x1234, then cpu_ready with cpu_rdata=0x1234 on cycle 4 after accept; miss_count=1.
REQ-039 SHALL verify writes: a write hit to 0x05 with data 0xA5A5 -> mem_we and cache_dwe each high for 1 cycle, cpu_ready after MEM_LAT+1 cycles; a write miss -> cache_dwe remains 0 and counters are unchanged.
REQ-040 SHALL verify saturation: with hit_count preloaded via 65535 hits, one further hit -> hit_count stays at 0xFFFF.
REQ-041 SHALL verify reset mid-MRD: reset asserted in the first MRD cycle -> FILL never occurs, cpu_ready=0, counters=0, and a subsequent read completes normally.
REQ-042 SHALL verify back-to-back requests: cpu_req held high across two hit reads -> the second is accepted exactly 1 cycle after the first cpu_ready, with the fields latched at that edge.
